// File: rtl/enc_pkg.sv
// Shared definitions for the registered priority encoder: mode encodings and
// the index-width helper used to size ports from N.
package enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceiling log2, usable in constant expressions; clog2(2) = 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational request scanner: masked pass from the start pointer first,
// unmasked pass as the wrap-around fallback.
module prio_enc_core
  import enc_pkg::*;
#(
  parameter int N     = 16,
  parameter int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  input  logic             mode,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [N-1:0]     mask;
  logic [N-1:0]     masked;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;
  logic             hi_found;
  logic             lo_found;

  // Fixed mode opens the whole mask so the first pass is plain LSB-wins.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign mask[gi] = (mode == MODE_FIXED) || (IDX_W'(gi) >= start);
    end
  endgenerate

  assign masked = req & mask;

  always_comb begin
    hi_idx   = '0;
    hi_found = 1'b0;
    lo_idx   = '0;
    lo_found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (masked[k]) begin
        hi_idx   = IDX_W'(k);
        hi_found = 1'b1;
      end
      if (req[k]) begin
        lo_idx   = IDX_W'(k);
        lo_found = 1'b1;
      end
    end
  end

  // The masked set is a subset of req, so the unmasked pass decides "found".
  assign found = lo_found;
  assign idx   = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/prio_enc_rr.sv
// Registered fixed/round-robin priority encoder with a valid/ready output stage.
// Optional PRIO_ENC_ONEHOT_EN adds a registered one-hot copy of the grant.
module prio_enc_rr
  import enc_pkg::*;
#(
  parameter int N        = 16,
  parameter int IDX_W    = clog2(N),
  parameter int RST_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  input  logic             mode_i,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  input  logic             out_ready,
  output logic             any_o,
  output logic [IDX_W-1:0] ptr_o
`ifdef PRIO_ENC_ONEHOT_EN
  ,
  output logic [N-1:0]     out_onehot
`endif
);

  logic             out_valid_reg;
  logic [IDX_W-1:0] out_idx_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic             load;
  logic             handshake;
  logic             unused_rst_mode;

  // RST_MODE is informational only; the scan mode always follows mode_i.
  assign unused_rst_mode = (RST_MODE != 0);

  prio_enc_core #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_core (
    .req   (req_i),
    .start (ptr_reg),
    .mode  (mode_i),
    .idx   (win_idx),
    .found (win_found)
  );

  assign load      = !out_valid_reg || out_ready;
  assign handshake = out_valid_reg && out_ready;

  // The new winner uses the pre-update pointer when load and handshake coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_idx_reg   <= '0;
      ptr_reg       <= '0;
    end else begin
      if (handshake) begin
        ptr_reg <= (out_idx_reg == IDX_W'(N - 1)) ? '0 : out_idx_reg + IDX_W'(1);
      end
      if (load) begin
        out_valid_reg <= win_found;
        out_idx_reg   <= win_found ? win_idx : '0;
      end
    end
  end

`ifdef PRIO_ENC_ONEHOT_EN
  logic [N-1:0] onehot_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      onehot_reg <= '0;
    end else if (load) begin
      onehot_reg <= win_found ? ({{(N - 1){1'b0}}, 1'b1} << win_idx) : '0;
    end
  end

  assign out_onehot = onehot_reg;
`endif

  assign out_valid = out_valid_reg;
  assign out_idx   = out_idx_reg;
  assign ptr_o     = ptr_reg;
  assign any_o     = |req_i;

endmodule
